// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: width, iteration count,
// FSM state encoding and a small conditional-invert helper for the adder muxes.
package shift_add_multiplier_pkg;

  localparam int MULT_W    = 32;
  localparam int MULT_ITER = 32;

  // Value of the iteration counter on the last RUN cycle
  localparam logic [4:0] LAST_ITER = 5'(MULT_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABS_A  = 3'd1,
    S_ABS_B  = 3'd2,
    S_RUN    = 3'd3,
    S_NEG_LO = 3'd4,
    S_NEG_HI = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  // One's complement of x when en is set; with cin=en the adder turns this
  // into a two's-complement negate.
  function automatic logic [MULT_W-1:0] cond_invert(input logic [MULT_W-1:0] x,
                                                    input logic              en);
    return x ^ {MULT_W{en}};
  endfunction

endpackage

// File: rtl/shift_add_multiplier_rca32.sv
// 32-bit ripple-carry adder shared by every step of the multiplier
// (absolute value, partial-product accumulate, result negate).
module shift_add_multiplier_rca32
  import shift_add_multiplier_pkg::*;
(
  input  logic [MULT_W-1:0] a_i,
  input  logic [MULT_W-1:0] b_i,
  input  logic              cin_i,
  output logic [MULT_W-1:0] sum_o,
  output logic              cout_o
);

  logic carry;

  // Bit-serial carry chain, LSB first
  always_comb begin
    sum_o = '0;
    carry = cin_i;
    for (int i = 0; i < MULT_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle 32x32->64 shift-add multiplier, unsigned or two's complement.
// Signed operands are converted to magnitudes, multiplied unsigned, and the
// 64-bit result is negated in two halves. All arithmetic goes through one
// ripple-carry adder whose operands are selected by FSM state.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  state_e             state_q, state_d;
  logic [MULT_W-1:0]  m_q, m_d;
  logic [MULT_W-1:0]  hi_q, hi_d;
  logic [MULT_W-1:0]  lo_q, lo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               sgn_q, sgn_d;
  logic               k_q, k_d;
  logic [63:0]        product_q, product_d;

  logic [MULT_W-1:0]  add_a, add_b, add_sum;
  logic               add_cin, add_cout;
  logic               accept;

  shift_add_multiplier_rca32 u_rca32 (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Adder operand selection; depends only on registered state
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state_q)
      S_ABS_A: begin
        add_a   = cond_invert(m_q, m_q[MULT_W-1]);
        add_cin = m_q[MULT_W-1];
      end
      S_ABS_B: begin
        add_a   = cond_invert(lo_q, lo_q[MULT_W-1]);
        add_cin = lo_q[MULT_W-1];
      end
      S_RUN: begin
        add_a = hi_q;
        add_b = lo_q[0] ? m_q : '0;
      end
      S_NEG_LO: begin
        add_a   = cond_invert(lo_q, neg_q);
        add_cin = neg_q;
      end
      S_NEG_HI: begin
        add_a   = cond_invert(hi_q, neg_q);
        add_cin = neg_q & k_q;
      end
      default: ;
    endcase
  end

  // A new request is taken in IDLE, and also in DONE so that back-to-back
  // operations start on the edge that leaves DONE.
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next-state and datapath register updates
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    sgn_d     = sgn_q;
    k_d       = k_q;
    product_d = product_q;

    unique case (state_q)
      S_IDLE: ;
      S_ABS_A: begin
        m_d     = add_sum;
        state_d = S_ABS_B;
      end
      S_ABS_B: begin
        lo_d    = add_sum;
        state_d = S_RUN;
      end
      S_RUN: begin
        // {HI,LO} <- {cout, sum, LO} >> 1
        hi_d  = {add_cout, add_sum[MULT_W-1:1]};
        lo_d  = {add_sum[0], lo_q[MULT_W-1:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          if (sgn_q) begin
            state_d = S_NEG_LO;
          end else begin
            state_d   = S_DONE;
            product_d = {hi_d, lo_d};
          end
        end
      end
      S_NEG_LO: begin
        lo_d    = add_sum;
        k_d     = add_cout;
        state_d = S_NEG_HI;
      end
      S_NEG_HI: begin
        hi_d      = add_sum;
        state_d   = S_DONE;
        product_d = {add_sum, lo_q};
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      m_d     = a;
      lo_d    = b;
      hi_d    = '0;
      cnt_d   = '0;
      k_d     = 1'b0;
      sgn_d   = is_signed;
      neg_d   = is_signed & (a[MULT_W-1] ^ b[MULT_W-1]);
      state_d = is_signed ? S_ABS_A : S_RUN;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      sgn_q     <= 1'b0;
      k_q       <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      sgn_q     <= sgn_d;
      k_q       <= k_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule
